// File: rtl/mem_wb_stage.sv
// MEM stage: sequences one load/store per instruction over a req/ack memory port, holds the MEM/WB register and drives the RF write port.
// Latency: MEM/WB updates one cycle after the instruction leaves MEM; a memory access stalls from the req cycle through the last no-ack cycle, so at least one cycle.
// Backpressure: memStall holds IF/ID/EX and EX/MEM while an access is outstanding; a timeout abandons the access and releases the stall.
module mem_wb_stage #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_EX_MEM,
  input  logic             flush_MEM,
  input  logic [3:0]       regAddr_EX_MEM,
  input  logic             regWe_EX_MEM,
  input  logic             jal_EX_MEM,
  input  logic             memToReg_EX_MEM,
  input  logic             memRe_EX_MEM,
  input  logic             memWe_EX_MEM,
  input  logic [15:0]      aluResult_EX_MEM,
  input  logic [15:0]      pcNext_EX_MEM,
  input  logic [15:0]      storeData,
  output logic             mem_req,
  output logic             mem_we,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic [15:0]      mem_rdata,
  output logic             memStall,
  output logic [3:0]       regAddr_MEM_WB,
  output logic             regWe_MEM_WB,
  output logic             jal_MEM_WB,
  output logic             memToReg_MEM_WB,
  output logic [15:0]      aluResult_MEM_WB,
  output logic [15:0]      pcNext_MEM_WB,
  output logic [15:0]      memData_MEM_WB,
  output logic             rfWe,
  output logic [3:0]       rfAddr,
  output logic [15:0]      rfData,
  output logic             memErr,
  output logic [CNT_W-1:0] stallCount
);

  localparam int WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [3:0]  reg_addr;
    logic        reg_we;
    logic        jal;
    logic        mem_to_reg;
    logic [15:0] alu_result;
    logic [15:0] pc_next;
    logic [15:0] mem_data;
  } wb_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              drop_q, drop_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  wb_t               wb_q, wb_d;

  logic access;
  logic req_raw;
  logic stall_raw;
  wb_t  ex_wb;

  // Sequencer next state, MEM/WB next value and stall/request generation
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    drop_d     = drop_q;
    mem_err_d  = mem_err_q;
    wb_d       = '0;
    req_raw    = 1'b0;
    stall_raw  = 1'b0;

    access = valid_EX_MEM & (memRe_EX_MEM | memWe_EX_MEM) & ~flush_MEM;

    // Fields as they would retire now; invalid or flushed slots lose their write enable.
    ex_wb            = '0;
    ex_wb.reg_addr   = regAddr_EX_MEM;
    ex_wb.reg_we     = regWe_EX_MEM & valid_EX_MEM & ~flush_MEM;
    ex_wb.jal        = jal_EX_MEM;
    ex_wb.mem_to_reg = memToReg_EX_MEM;
    ex_wb.alu_result = aluResult_EX_MEM;
    ex_wb.pc_next    = pcNext_EX_MEM;

    case (state_q)
      S_IDLE: begin
        if (access) begin
          // Single-cycle request pulse; the instruction waits in EX/MEM under stall.
          req_raw    = 1'b1;
          stall_raw  = 1'b1;
          state_d    = S_WAIT;
          wait_cnt_d = '0;
          drop_d     = 1'b0;
        end else begin
          wb_d = ex_wb;
        end
      end
      S_WAIT: begin
        // A flush while waiting cannot cancel the memory transaction, only its retirement.
        if (flush_MEM) begin
          drop_d = 1'b1;
        end
        if (mem_ack) begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
          if (!(drop_q | flush_MEM)) begin
            wb_d          = ex_wb;
            wb_d.mem_data = mem_rdata;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Abandon the access: bubble into MEM/WB and let the pipeline move on.
          state_d   = S_IDLE;
          drop_d    = 1'b0;
          mem_err_d = 1'b1;
        end else begin
          stall_raw  = 1'b1;
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    stall_cnt_d = stall_cnt_q;
    if (stall_raw && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State, MEM/WB register, sticky error and stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      drop_q      <= 1'b0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      wb_q        <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      drop_q      <= drop_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      wb_q        <= wb_d;
    end
  end

  // Request and stall are quiet while reset is held.
  assign mem_req   = req_raw & ~rst;
  assign memStall  = stall_raw & ~rst;
  assign mem_we    = mem_req & memWe_EX_MEM;
  assign mem_addr  = aluResult_EX_MEM;
  assign mem_wdata = storeData;

  assign regAddr_MEM_WB   = wb_q.reg_addr;
  assign regWe_MEM_WB     = wb_q.reg_we;
  assign jal_MEM_WB       = wb_q.jal;
  assign memToReg_MEM_WB  = wb_q.mem_to_reg;
  assign aluResult_MEM_WB = wb_q.alu_result;
  assign pcNext_MEM_WB    = wb_q.pc_next;
  assign memData_MEM_WB   = wb_q.mem_data;

  assign memErr     = mem_err_q;
  assign stallCount = stall_cnt_q;

  // Register-file write port; R0 is hardwired and never written
  always_comb begin
    rfAddr = wb_q.reg_addr;
    rfWe   = wb_q.reg_we & (wb_q.reg_addr != 4'd0);
    if (wb_q.jal) begin
      rfData = wb_q.pc_next;
    end else if (wb_q.mem_to_reg) begin
      rfData = wb_q.mem_data;
    end else begin
      rfData = wb_q.alu_result;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: scoreboard of expected RF writes, memory responder with programmable ack delay.
module tb_mem_wb_stage;
  localparam int MAX_WAIT = 64;
  localparam int CNT_W    = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_EX_MEM, flush_MEM;
  logic [3:0]       regAddr_EX_MEM;
  logic             regWe_EX_MEM, jal_EX_MEM, memToReg_EX_MEM, memRe_EX_MEM, memWe_EX_MEM;
  logic [15:0]      aluResult_EX_MEM, pcNext_EX_MEM, storeData;
  logic             mem_req, mem_we;
  logic [15:0]      mem_addr, mem_wdata;
  logic             mem_ack;
  logic [15:0]      mem_rdata;
  logic             memStall;
  logic [3:0]       regAddr_MEM_WB;
  logic             regWe_MEM_WB, jal_MEM_WB, memToReg_MEM_WB;
  logic [15:0]      aluResult_MEM_WB, pcNext_MEM_WB, memData_MEM_WB;
  logic             rfWe;
  logic [3:0]       rfAddr;
  logic [15:0]      rfData;
  logic             memErr;
  logic [CNT_W-1:0] stallCount;

  typedef struct packed {
    logic        we;
    logic [3:0]  addr;
    logic [15:0] data;
  } wb_exp_t;

  wb_exp_t sb_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int total_stalls = 0;
  int st, rq;

  always #5 clk = ~clk;

  mem_wb_stage #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .valid_EX_MEM(valid_EX_MEM), .flush_MEM(flush_MEM),
    .regAddr_EX_MEM(regAddr_EX_MEM), .regWe_EX_MEM(regWe_EX_MEM),
    .jal_EX_MEM(jal_EX_MEM), .memToReg_EX_MEM(memToReg_EX_MEM),
    .memRe_EX_MEM(memRe_EX_MEM), .memWe_EX_MEM(memWe_EX_MEM),
    .aluResult_EX_MEM(aluResult_EX_MEM), .pcNext_EX_MEM(pcNext_EX_MEM),
    .storeData(storeData),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .memStall(memStall),
    .regAddr_MEM_WB(regAddr_MEM_WB), .regWe_MEM_WB(regWe_MEM_WB),
    .jal_MEM_WB(jal_MEM_WB), .memToReg_MEM_WB(memToReg_MEM_WB),
    .aluResult_MEM_WB(aluResult_MEM_WB), .pcNext_MEM_WB(pcNext_MEM_WB),
    .memData_MEM_WB(memData_MEM_WB),
    .rfWe(rfWe), .rfAddr(rfAddr), .rfData(rfData),
    .memErr(memErr), .stallCount(stallCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_ex();
    valid_EX_MEM     = 1'b0;
    flush_MEM        = 1'b0;
    regAddr_EX_MEM   = 4'd0;
    regWe_EX_MEM     = 1'b0;
    jal_EX_MEM       = 1'b0;
    memToReg_EX_MEM  = 1'b0;
    memRe_EX_MEM     = 1'b0;
    memWe_EX_MEM     = 1'b0;
    aluResult_EX_MEM = 16'h0;
    pcNext_EX_MEM    = 16'h0;
    storeData        = 16'h0;
  endtask

  // Present one instruction, act as the memory, then check the retired RF write.
  // ack_after: number of no-ack WAIT cycles before ack (-1 = never). flush_at: cycle index of a flush pulse (-1 = none).
  task automatic run_instr(input string tag, input logic [3:0] ra, input logic rwe, input logic jal,
                           input logic m2r, input logic re, input logic wr,
                           input logic [15:0] alu, input logic [15:0] pc, input logic [15:0] sd,
                           input logic [15:0] rdata, input int ack_after, input int flush_at,
                           output int stalls, output int reqs);
    wb_exp_t e;
    wb_exp_t got;
    logic    done;
    logic    is_mem;
    is_mem = re | wr;
    e = '0;
    // A timed-out or flushed access retires as an all-zero bubble.
    if (!(is_mem && (ack_after < 0 || flush_at >= 0))) begin
      e.we   = rwe && (ra != 4'd0);
      e.addr = ra;
      e.data = jal ? pc : (m2r ? (is_mem ? rdata : 16'h0) : alu);
    end
    sb_q.push_back(e);

    valid_EX_MEM     = 1'b1;
    regAddr_EX_MEM   = ra;
    regWe_EX_MEM     = rwe;
    jal_EX_MEM       = jal;
    memToReg_EX_MEM  = m2r;
    memRe_EX_MEM     = re;
    memWe_EX_MEM     = wr;
    aluResult_EX_MEM = alu;
    pcNext_EX_MEM    = pc;
    storeData        = sd;
    stalls = 0;
    reqs   = 0;
    done   = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      mem_ack   = (k >= 1) && (ack_after >= 0) && ((k - 1) == ack_after);
      mem_rdata = mem_ack ? rdata : 16'hDEAD;
      flush_MEM = (k == flush_at);
      #1;
      if (mem_req) begin
        reqs++;
        check({tag, "_mem_addr"}, mem_addr, alu);
        check({tag, "_mem_we"}, mem_we, wr);
        check({tag, "_mem_wdata"}, mem_wdata, sd);
      end
      if (memStall) stalls++;
      else done = 1'b1;
      @(posedge clk);
      #1;
    end
    check({tag, "_released"}, done, 1'b1);
    total_stalls += stalls;
    idle_ex();
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    #1;
    got = sb_q.pop_front();
    check({tag, "_rfWe"}, rfWe, got.we);
    check({tag, "_rfAddr"}, rfAddr, got.addr);
    check({tag, "_rfData"}, rfData, got.data);
  endtask

  initial begin
    rst = 1'b1;
    idle_ex();
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_memStall", memStall, 1'b0);
    check("rst_rfWe", rfWe, 1'b0);
    check("rst_wb_fields", {regAddr_MEM_WB, regWe_MEM_WB, jal_MEM_WB, memToReg_MEM_WB}, 7'h0);
    check("rst_wb_data", {aluResult_MEM_WB, pcNext_MEM_WB}, 32'h0);
    check("rst_memErr", memErr, 1'b0);
    check("rst_stallCount", stallCount, 16'h0);
    rst = 1'b0;

    // Plain ALU op
    run_instr("alu", 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0010, 16'h0, 16'h0, -1, -1, st, rq);
    check("alu_stalls", st, 0);
    check("alu_reqs", rq, 0);

    // Load, two no-ack wait cycles then ack: three stall cycles
    run_instr("load", 4'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0020, 16'h0, 16'hBEEF, 2, -1, st, rq);
    check("load_stalls", st, 3);
    check("load_reqs", rq, 1);
    check("load_memData", memData_MEM_WB, 16'hBEEF);
    check("load_stallCount", stallCount, total_stalls);

    // Store acked in the first wait cycle
    run_instr("store", 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0080, 16'h0030, 16'h55AA, 16'h1111, 0, -1, st, rq);
    check("store_stalls", st, 1);
    check("store_reqs", rq, 1);

    // Link write to R15
    run_instr("jal", 4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h9999, 16'h0102, 16'h0, 16'h0, -1, -1, st, rq);
    check("jal_stalls", st, 0);

    // Write to R0 is suppressed at the port but kept in MEM/WB
    run_instr("r0", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7777, 16'h0040, 16'h0, 16'h0, -1, -1, st, rq);
    check("r0_regWe_MEM_WB", regWe_MEM_WB, 1'b1);

    // Flush while waiting, then ack: bubble; following op is unaffected
    run_instr("flush", 4'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0044, 16'h0050, 16'h0, 16'hCAFE, 2, 1, st, rq);
    check("flush_stalls", st, 3);
    check("flush_reqs", rq, 1);
    check("flush_regWe_MEM_WB", regWe_MEM_WB, 1'b0);
    run_instr("after_flush", 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00A5, 16'h0060, 16'h0, 16'h0, -1, -1, st, rq);
    check("after_flush_stalls", st, 0);

    // Timeout: no ack ever
    run_instr("timeout", 4'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0048, 16'h0070, 16'h0, 16'h0, -1, -1, st, rq);
    check("timeout_stalls", st, MAX_WAIT);
    check("timeout_reqs", rq, 1);
    check("timeout_memErr", memErr, 1'b1);
    check("timeout_memStall", memStall, 1'b0);
    check("timeout_stallCount", stallCount, total_stalls);

    // Stray ack in IDLE is ignored
    mem_ack   = 1'b1;
    mem_rdata = 16'h3333;
    #1;
    check("stray_mem_req", mem_req, 1'b0);
    check("stray_memStall", memStall, 1'b0);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    check("stray_rfWe", rfWe, 1'b0);
    check("stray_memData", memData_MEM_WB, 16'h0);
    check("stray_memErr", memErr, 1'b1);
    run_instr("post_timeout", 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0BAD, 16'h0080, 16'h0, 16'h0, -1, -1, st, rq);
    check("post_timeout_memErr", memErr, 1'b1);

    // Reset in the middle of a wait, ack arriving the cycle after
    valid_EX_MEM     = 1'b1;
    regAddr_EX_MEM   = 4'd11;
    regWe_EX_MEM     = 1'b1;
    memToReg_EX_MEM  = 1'b1;
    memRe_EX_MEM     = 1'b1;
    aluResult_EX_MEM = 16'h00C0;
    #1;
    check("rstwait_mem_req", mem_req, 1'b1);
    @(posedge clk);
    #1;
    check("rstwait_memStall", memStall, 1'b1);
    rst = 1'b1;
    idle_ex();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 16'h4444;
    #1;
    check("rstwait_idle_stall", memStall, 1'b0);
    check("rstwait_idle_req", mem_req, 1'b0);
    check("rstwait_wb_fields", {regAddr_MEM_WB, regWe_MEM_WB, jal_MEM_WB, memToReg_MEM_WB}, 7'h0);
    check("rstwait_wb_data", {aluResult_MEM_WB, pcNext_MEM_WB}, 32'h0);
    check("rstwait_memData", memData_MEM_WB, 16'h0);
    check("rstwait_memErr", memErr, 1'b0);
    check("rstwait_stallCount", stallCount, 16'h0);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    check("rstwait_ack_rfWe", rfWe, 1'b0);
    check("rstwait_ack_memData", memData_MEM_WB, 16'h0);
    check("rstwait_ack_stallCount", stallCount, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
